// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared definitions for the load/store-multiple block-transfer sequencer.
package ldm_stm_sequencer_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_WBACK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ldm_stm_sequencer_priority_encoder_16.sv
// Lowest-set-bit index of a 16-bit mask; returns 0 for an empty mask.
module priority_encoder_16 (
    input  logic [15:0] mask,
    output logic [3:0]  idx
);

    always_comb begin
        idx = '0;
        // Scanning downwards lets the lowest set bit win.
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) idx = 4'(i);
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Sequences an LDM/STM block transfer: one memory beat per selected register,
// ascending register order, optional base-register writeback.
module ldm_stm_sequencer
    import ldm_stm_sequencer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              load,
    input  logic [15:0]       reg_list,
    input  logic [3:0]        base_reg,
    input  logic [DATA_W-1:0] base_val,
    input  logic              up,
    input  logic              pre,
    input  logic              wback,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [3:0]        rf_read_sel,
    output logic [3:0]        rf_write_sel,
    output logic              rf_wr_en_n,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              done
);

    localparam logic [DATA_W-1:0] BEAT_STEP = DATA_W'(WORD_BYTES);

    state_e            state_q, state_d;
    logic              load_q, load_d;
    logic              wback_q, wback_d;
    logic              skip_wb_q, skip_wb_d;
    logic [15:0]       mask_q, mask_d;
    logic [3:0]        base_reg_q, base_reg_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] final_base_q, final_base_d;

    logic [3:0]        cur_idx;
    logic [4:0]        n_set;
    logic [DATA_W-1:0] n_bytes;

    priority_encoder_16 u_penc (
        .mask (mask_q),
        .idx  (cur_idx)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d      = state_q;
        load_d       = load_q;
        wback_d      = wback_q;
        skip_wb_d    = skip_wb_q;
        mask_d       = mask_q;
        base_reg_d   = base_reg_q;
        addr_d       = addr_q;
        final_base_d = final_base_q;
        n_set        = popcount16(reg_list);
        n_bytes      = DATA_W'(n_set) * BEAT_STEP;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        rf_read_sel  = '0;
        rf_write_sel = '0;
        rf_wr_en_n   = 1'b1;
        rf_wdata     = '0;
        done         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_d       = load;
                    wback_d      = wback;
                    mask_d       = reg_list;
                    base_reg_d   = base_reg;
                    // A load that overwrites the base register wins over the writeback.
                    skip_wb_d    = load & reg_list[base_reg];
                    final_base_d = up ? base_val + n_bytes : base_val - n_bytes;
                    case ({up, pre})
                        2'b10:   addr_d = base_val;
                        2'b11:   addr_d = base_val + BEAT_STEP;
                        2'b00:   addr_d = base_val - n_bytes + BEAT_STEP;
                        default: addr_d = base_val - n_bytes;
                    endcase
                    state_d = (n_set == 5'd0) ? ST_DONE : ST_XFER;
                end
            end
            ST_XFER: begin
                mem_req     = 1'b1;
                mem_we      = ~load_q;
                mem_addr    = addr_q;
                rf_read_sel = cur_idx;
                if (mem_ack) begin
                    if (load_q) begin
                        rf_wr_en_n   = 1'b0;
                        rf_write_sel = cur_idx;
                        rf_wdata     = mem_rdata;
                    end
                    mask_d = mask_q & ~(16'd1 << cur_idx);
                    addr_d = addr_q + BEAT_STEP;
                    if (mask_d == 16'd0) begin
                        state_d = wback_q ? ST_WBACK : ST_DONE;
                    end
                end
            end
            ST_WBACK: begin
                rf_write_sel = base_reg_q;
                rf_wdata     = final_base_q;
                rf_wr_en_n   = skip_wb_q;
                state_d      = ST_DONE;
            end
            default: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            load_q       <= 1'b0;
            wback_q      <= 1'b0;
            skip_wb_q    <= 1'b0;
            mask_q       <= '0;
            base_reg_q   <= '0;
            addr_q       <= '0;
            final_base_q <= '0;
        end else begin
            // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            load_q       <= load_d;
            wback_q      <= wback_d;
            skip_wb_q    <= skip_wb_d;
            mask_q       <= mask_d;
            base_reg_q   <= base_reg_d;
            addr_q       <= addr_d;
            final_base_q <= final_base_d;
        end
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: per-scenario cycle tables with hand-derived outputs.
module tb_ldm_stm_sequencer;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic          load;
    logic [15:0]   reg_list;
    logic [3:0]    base_reg;
    logic [DW-1:0] base_val;
    logic          up;
    logic          pre;
    logic          wback;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [3:0]    rf_read_sel;
    logic [3:0]    rf_write_sel;
    logic          rf_wr_en_n;
    logic [DW-1:0] rf_wdata;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;

    ldm_stm_sequencer #(.DATA_W(DW)) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .load         (load),
        .reg_list     (reg_list),
        .base_reg     (base_reg),
        .base_val     (base_val),
        .up           (up),
        .pre          (pre),
        .wback        (wback),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .rf_read_sel  (rf_read_sel),
        .rf_write_sel (rf_write_sel),
        .rf_wr_en_n   (rf_wr_en_n),
        .rf_wdata     (rf_wdata),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Register-file writes actually committed at a clock edge.
    always @(posedge clk) begin
        if (!rf_wr_en_n && !clr) wr_count <= wr_count + 1;
    end

    typedef struct packed {
        logic          req;
        logic          we;
        logic [DW-1:0] addr;
        logic [3:0]    rsel;
        logic [3:0]    wsel;
        logic          wr_n;
        logic [DW-1:0] wdata;
        logic          busy;
        logic          done;
    } obs_t;

    function automatic obs_t snap_raw();
        obs_t o;
        o.req   = mem_req;
        o.we    = mem_we;
        o.addr  = mem_addr;
        o.rsel  = rf_read_sel;
        o.wsel  = rf_write_sel;
        o.wr_n  = rf_wr_en_n;
        o.wdata = rf_wdata;
        o.busy  = busy;
        o.done  = done;
        return o;
    endfunction

    // Address/read-select only matter with mem_req; write select/data only with the strobe low.
    function automatic obs_t snap();
        obs_t o;
        o = snap_raw();
        if (!o.req) begin
            o.addr = '0;
            o.rsel = '0;
        end
        if (o.wr_n) begin
            o.wsel  = '0;
            o.wdata = '0;
        end
        return o;
    endfunction

    function automatic obs_t mk(input int req, input int we, input logic [DW-1:0] addr,
                                input int rsel, input int wr_n, input int wsel,
                                input logic [DW-1:0] wdata, input int bsy, input int dn);
        obs_t o;
        o.req   = req[0];
        o.we    = we[0];
        o.addr  = addr;
        o.rsel  = rsel[3:0];
        o.wsel  = wsel[3:0];
        o.wr_n  = wr_n[0];
        o.wdata = wdata;
        o.busy  = bsy[0];
        o.done  = dn[0];
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents a one-cycle start with the given operands; returns in the first cycle after it.
    task automatic issue(input logic ld, input logic [15:0] lst, input logic [3:0] breg,
                         input logic [DW-1:0] base, input logic u, input logic p, input logic wb);
        load     = ld;
        reg_list = lst;
        base_reg = breg;
        base_val = base;
        up       = u;
        pre      = p;
        wback    = wb;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t exp;
        clr = 1'b1; start = 1'b0; load = 1'b0; reg_list = '0; base_reg = '0; base_val = '0;
        up = 1'b0; pre = 1'b0; wback = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        step();
        exp = mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0);
        // Start while held in reset must not launch a transfer.
        reg_list = 16'h0001; start = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        got = snap_raw();
        if (got !== exp) begin
            $display("FAIL reset_values: got %h, expected %h", got, exp); n_fail++;
        end
        n_tests++;
        step();
        start = 1'b0; clr = 1'b0; reg_list = '0; mem_ack = 1'b0; mem_rdata = '0;
        step();
        #1;
        got = snap_raw();
        if (got !== exp) begin
            $display("FAIL reset_release_idle: got %h, expected %h", got, exp); n_fail++;
        end
        n_tests++;
        step();
    endtask

    task automatic test_ldm_ia();
        obs_t got;
        obs_t exp [4];
        logic [DW-1:0] rd [4] = '{32'hD0, 32'hD2, 32'h0, 32'h0};
        int wr0;
        exp[0] = mk(1, 0, 32'h100, 0, 0, 0, 32'hD0, 1, 0);
        exp[1] = mk(1, 0, 32'h104, 2, 0, 2, 32'hD2, 1, 0);
        exp[2] = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,  1, 1);
        exp[3] = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,  0, 0);
        wr0 = wr_count;
        mem_ack = 1'b1;
        issue(1'b1, 16'h0005, 4'd13, 32'h100, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            mem_rdata = rd[c];
            #1;
            got = snap();
            if (got !== exp[c]) begin
                $display("FAIL ldm_ia cycle %0d: got %h, expected %h", c + 1, got, exp[c]); n_fail++;
            end
            n_tests++;
            step();
        end
        if (wr_count - wr0 !== 2) begin
            $display("FAIL ldm_ia_writes: got %0d, expected 2", wr_count - wr0); n_fail++;
        end
        n_tests++;
        mem_ack = 1'b0;
    endtask

    // Shared runner for store scenarios with ack every cycle and five observed cycles.
    task automatic test_stm(input string name, input logic [15:0] lst, input logic [3:0] breg,
                            input logic [DW-1:0] base, input logic u, input logic p,
                            input obs_t e0, input obs_t e1, input obs_t e2, input obs_t e3);
        obs_t got;
        obs_t exp [5];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        exp[4] = mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        issue(1'b0, lst, breg, base, u, p, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            got = snap();
            if (got !== exp[c]) begin
                $display("FAIL %s cycle %0d: got %h, expected %h", name, c + 1, got, exp[c]); n_fail++;
            end
            n_tests++;
            step();
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_ldm_wait();
        obs_t got;
        obs_t exp [6];
        logic ack [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic stt [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int wr0;
        exp[0] = mk(1, 0, 32'h44, 1, 1, 0, 32'h0, 1, 0);
        exp[1] = exp[0];
        exp[2] = exp[0];
        exp[3] = mk(1, 0, 32'h44, 1, 0, 1, 32'h1234_5678, 1, 0);
        exp[4] = mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 1, 1);
        exp[5] = mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0);
        wr0 = wr_count;
        mem_ack = 1'b0;
        issue(1'b1, 16'h0002, 4'd0, 32'h40, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 6; c++) begin
            mem_ack   = ack[c];
            start     = stt[c];
            mem_rdata = 32'h1234_5678;
            // Operand inputs wander while busy; the latched copies must not follow.
            base_val  = stt[c] ? 32'hDEAD_BEEF : 32'h40;
            reg_list  = stt[c] ? 16'hFFFF : 16'h0002;
            load      = ~stt[c];
            #1;
            got = snap();
            if (got !== exp[c]) begin
                $display("FAIL ldm_wait cycle %0d: got %h, expected %h", c + 1, got, exp[c]); n_fail++;
            end
            n_tests++;
            step();
        end
        if (wr_count - wr0 !== 1) begin
            $display("FAIL ldm_wait_writes: got %0d, expected 1", wr_count - wr0); n_fail++;
        end
        n_tests++;
        mem_ack = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_empty_list();
        obs_t got;
        obs_t exp [2];
        int wr0;
        exp[0] = mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 1, 1);
        exp[1] = mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0);
        wr0 = wr_count;
        mem_ack = 1'b1;
        issue(1'b1, 16'h0000, 4'd4, 32'h80, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #1;
            got = snap_raw();
            if (got !== exp[c]) begin
                $display("FAIL empty_list cycle %0d: got %h, expected %h", c + 1, got, exp[c]); n_fail++;
            end
            n_tests++;
            step();
        end
        if (wr_count - wr0 !== 0) begin
            $display("FAIL empty_list_writes: got %0d, expected 0", wr_count - wr0); n_fail++;
        end
        n_tests++;
        mem_ack = 1'b0;
    endtask

    task automatic test_clr_mid();
        obs_t got;
        obs_t exp_beat;
        obs_t exp_rst;
        int wr0;
        exp_beat = mk(1, 0, 32'h300, 1, 0, 1, 32'hAB, 1, 0);
        exp_rst  = mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0);
        wr0 = wr_count;
        mem_ack = 1'b1;
        mem_rdata = 32'hAB;
        issue(1'b1, 16'h0006, 4'd0, 32'h300, 1'b1, 1'b0, 1'b1);
        #1;
        got = snap();
        if (got !== exp_beat) begin
            $display("FAIL clr_mid_first_beat: got %h, expected %h", got, exp_beat); n_fail++;
        end
        n_tests++;
        step();
        clr = 1'b1;
        #1;
        got = snap_raw();
        if (got !== exp_rst) begin
            $display("FAIL clr_mid_immediate: got %h, expected %h", got, exp_rst); n_fail++;
        end
        n_tests++;
        step();
        clr = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            got = snap_raw();
            if (got !== exp_rst) begin
                $display("FAIL clr_mid_after %0d: got %h, expected %h", c, got, exp_rst); n_fail++;
            end
            n_tests++;
            step();
        end
        if (wr_count - wr0 !== 1) begin
            $display("FAIL clr_mid_writes: got %0d, expected 1", wr_count - wr0); n_fail++;
        end
        n_tests++;
        mem_ack = 1'b0;
    endtask

    task automatic test_base_in_list();
        obs_t got;
        obs_t exp [4];
        int wr0;
        exp[0] = mk(1, 0, 32'h10, 3, 0, 3, 32'hCAFE, 1, 0);
        exp[1] = mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 1, 0);
        exp[2] = mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 1, 1);
        exp[3] = mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0);
        wr0 = wr_count;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE;
        issue(1'b1, 16'h0008, 4'd3, 32'h10, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1;
            got = snap();
            if (got !== exp[c]) begin
                $display("FAIL base_in_list cycle %0d: got %h, expected %h", c + 1, got, exp[c]); n_fail++;
            end
            n_tests++;
            step();
        end
        if (wr_count - wr0 !== 1) begin
            $display("FAIL base_in_list_writes: got %0d, expected 1", wr_count - wr0); n_fail++;
        end
        n_tests++;
        mem_ack = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ldm_ia();
        // STM decrement-before: 0x200 - 8 = 0x1F8 start, base written 0x1F8.
        test_stm("stm_db", 16'h8001, 4'd5, 32'h200, 1'b0, 1'b1,
                 mk(1, 1, 32'h1F8, 0, 1, 0, 32'h0, 1, 0),
                 mk(1, 1, 32'h1FC, 15, 1, 0, 32'h0, 1, 0),
                 mk(0, 0, 32'h0, 0, 0, 5, 32'h1F8, 1, 0),
                 mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 1, 1));
        // STM decrement-after: 0x1000 - 8 + 4 = 0xFFC start, base written 0xFF8.
        test_stm("stm_da", 16'h0110, 4'd2, 32'h1000, 1'b0, 1'b0,
                 mk(1, 1, 32'hFFC, 4, 1, 0, 32'h0, 1, 0),
                 mk(1, 1, 32'h1000, 8, 1, 0, 32'h0, 1, 0),
                 mk(0, 0, 32'h0, 0, 0, 2, 32'hFF8, 1, 0),
                 mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 1, 1));
        test_ldm_wait();
        test_empty_list();
        test_clr_mid();
        test_base_in_list();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 Parameter DATA_W, default 32: width of data, address and base operands.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 clr  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle request to begin a block transfer; sampled only in IDLE.
REQ-005 load  in  1  1 = LDM (memory to registers), 0 = STM (registers to memory).
REQ-006 reg_list  in  16  register mask; bit i selects register i.
REQ-007 base_reg  in  4  number of the base register.
REQ-008 base_val  in  DATA_W  current base register value.
REQ-009 up  in  1  1 = increment addressing, 0 = decrement.
REQ-010 pre  in  1  1 = adjust before access, 0 = after.
REQ-011 wback  in  1  1 = write final base to base_reg.
REQ-012 mem_ack  in  1  memory completes the current beat.
REQ-013 mem_rdata  in  DATA_W  load data, valid with mem_ack.
REQ-014 mem_req  out  1  memory beat request, held until mem_ack.
REQ-015 mem_we  out  1  1 = store beat.
REQ-016 mem_addr  out  DATA_W  beat byte address.
REQ-017 rf_read_sel  out  4  register-file read port select (store data source).
REQ-018 rf_write_sel  out  4  register-file write select.
REQ-019 rf_wr_en_n  out  1  register-file write strobe, active-low.
REQ-020 rf_wdata  out  DATA_W  register-file write data.
REQ-021 busy  out  1  high in any state other than IDLE.
REQ-022 done  out  1  one-cycle pulse when the transfer completes.

Function
REQ-023 FSM states: IDLE, XFER, WBACK, DONE; register transitions only.
REQ-024 IDLE with start=1: latch all inputs, n = popcount(reg_list), go to XFER (or DONE if n=0).
REQ-025 Start address: IA=base, IB=base+4, DA=base-4n+4, DB=base-4n; arithmetic modulo 2^DATA_W.
REQ-026 Registers are transferred in ascending number order; address increases by 4 per beat regardless of up.
REQ-027 XFER: mem_req=1, mem_addr=current address, rf_read_sel=current register; beat ends on the cycle mem_ack=1.
REQ-028 LDM beat: on the mem_ack cycle, rf_wr_en_n=0, rf_write_sel=current register, rf_wdata=mem_rdata (same cycle, combinational).
REQ-029 STM beat: rf_wr_en_n stays 1; mem_we=1 throughout XFER.
REQ-030 After the ack of the last selected register: go to WBACK if wback=1, else DONE; otherwise advance to next set bit next cycle with no idle cycle.
REQ-031 WBACK (one cycle): rf_write_sel=base_reg, rf_wdata=base±4n, rf_wr_en_n=0, except skipped (strobe held high) for LDM with base_reg in reg_list.
REQ-032 DONE (one cycle): done=1, then IDLE; done never coincides with rf_wr_en_n=0.
REQ-033 n=0: no beats, no writeback; done pulses two cycles after start.
REQ-034 start outside IDLE is ignored; latched operands are immune to input changes.
REQ-035 Outside XFER: mem_req=0, mem_we=0; outside LDM ack/WBACK: rf_wr_en_n=1.

Reset
REQ-036 clr=1 forces IDLE immediately, including mid-transfer; pending beat abandoned, no further writes.
REQ-037 Reset values: mem_req=0, mem_we=0, mem_addr=0, rf_read_sel=0, rf_write_sel=0, rf_wr_en_n=1, rf_wdata=0, busy=0, done=0.

Structure
REQ-038 Shared package holds the FSM state encoding and the WORD_BYTES=4 constant.
REQ-039 One sub-module, priority_encoder_16, returns the lowest set bit index of the remaining mask.

Verification
REQ-040 LDM IA, base=0x100, list=0x0005, ack every cycle -> R0@0x100, R2@0x104, done 4 cycles after start.
REQ-041 STM DB, base=0x200, list=0x8001, wback -> addrs 0x1F8, 0x1FC; base_reg written 0x1F8.
REQ-042 LDM, list=0x0002, mem_ack delayed 3 cycles -> mem_req/mem_addr held stable, single write of R1.
REQ-043 reg_list=0 with wback -> no mem_req, no write, done pulse at cycle 2.
REQ-044 clr asserted during second beat -> outputs at reset values same cycle, no writeback.
REQ-045 LDM IA wback, base_reg=3, list=0x0008 -> R3 gets load data, writeback suppressed.
